// File: rtl/frame_fifo_pkg.sv
// Shared types and sizing helpers for the frame FIFO: entry layout, depth and level width.
package frame_fifo_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ADDR_W = 4;

  typedef struct packed {
    logic                  eod;
    logic [DEF_DATA_W-1:0] data;
  } entry_t;

  function automatic int unsigned fifoDepth(input int unsigned addrW);
    return 32'd1 << addrW;
  endfunction

  // One extra bit so a completely full FIFO is representable.
  function automatic int unsigned levelWidth(input int unsigned addrW);
    return addrW + 1;
  endfunction

endpackage

// File: rtl/frame_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read; swappable for a RAM primitive.
module frame_fifo_ram #(
  parameter int unsigned WIDTH  = 9,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/frame_fifo_sync.sv
// Single-clock FWFT frame FIFO with EOD tagging, thresholds, frame count and error pulses.
// Define FRAME_FIFO_DROP_EN to hide partial frames behind a commit pointer and drop overflowing frames.
module frame_fifo_sync
  import frame_fifo_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned AEMPTY_TH = 2,
  parameter int unsigned AFULL_TH  = 12
) (
  input  logic              CLK_IN,
  input  logic              RST_N,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_eod,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_eod,
  output logic              empty,
  output logic              aempty,
  output logic              full,
  output logic              afull,
  output logic [ADDR_W:0]   level,
  output logic [ADDR_W:0]   frame_cnt,
  output logic              overflow,
  output logic              underflow
`ifdef FRAME_FIFO_DROP_EN
  ,
  output logic              frame_drop
`endif
);

  localparam int unsigned   LW        = levelWidth(ADDR_W);
  localparam int unsigned   DEPTH     = fifoDepth(ADDR_W);
  localparam logic [LW-1:0] ONE       = LW'(1);
  localparam logic [LW-1:0] DEPTH_LV  = LW'(DEPTH);
  localparam logic [LW-1:0] AEMPTY_LV = LW'(AEMPTY_TH);
  localparam logic [LW-1:0] AFULL_LV  = LW'(AFULL_TH);

  // Same field order as entry_t, widened to this instance's DATA_W.
  typedef struct packed {
    logic              eod;
    logic [DATA_W-1:0] data;
  } slot_t;

  logic [LW-1:0] wrPtr_q, wrPtr_d;
  logic [LW-1:0] rdPtr_q, rdPtr_d;
  logic [LW-1:0] frameCnt_q, frameCnt_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic [LW-1:0] visPtr;
  logic [LW-1:0] visLevel;
  logic [LW-1:0] totalLevel;
  logic          rdAccept;
  logic          wrAccept;
  logic          wrReject;
  slot_t         wrSlot;
  slot_t         rdSlot;

`ifdef FRAME_FIFO_DROP_EN
  logic [LW-1:0] commitPtr_q, commitPtr_d;
  logic          dropping_q, dropping_d;
  logic          frameDrop_q, frameDrop_d;

  assign visPtr   = commitPtr_q;
  assign wrAccept = wr_en & ~dropping_q & (~full | rdAccept);
  assign wrReject = wr_en & ~dropping_q & full & ~rdAccept;
  assign frame_drop = frameDrop_q;
`else
  assign visPtr   = wrPtr_q;
  assign wrAccept = wr_en & (~full | rdAccept);
  assign wrReject = wr_en & ~wrAccept;
`endif

  // The reader sees visible entries; capacity is judged on everything written.
  assign visLevel   = visPtr - rdPtr_q;
  assign totalLevel = wrPtr_q - rdPtr_q;
  assign empty      = (visLevel == '0);
  assign aempty     = (visLevel <= AEMPTY_LV);
  assign full       = (totalLevel == DEPTH_LV);
  assign afull      = (totalLevel >= AFULL_LV);
  assign level      = visLevel;
  assign frame_cnt  = frameCnt_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;
  assign rdAccept   = rd_en & ~empty;

  assign wrSlot.eod  = wr_eod;
  assign wrSlot.data = wr_data;
  assign rd_data     = rdSlot.data;
  assign rd_eod      = rdSlot.eod;

  frame_fifo_ram #(
    .WIDTH  (DATA_W + 1),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (CLK_IN),
    .we_i    (wrAccept),
    .waddr_i (wrPtr_q[ADDR_W-1:0]),
    .wdata_i (wrSlot),
    .raddr_i (rdPtr_q[ADDR_W-1:0]),
    .rdata_o (rdSlot)
  );

  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    frameCnt_d  = frameCnt_q;
    overflow_d  = wrReject;
    underflow_d = rd_en & empty;

    if (wrAccept) begin
      wrPtr_d = wrPtr_q + ONE;
    end
    if (rdAccept) begin
      rdPtr_d = rdPtr_q + ONE;
    end

    case ({wrAccept & wr_eod, rdAccept & rd_eod})
      2'b10:   frameCnt_d = frameCnt_q + ONE;
      2'b01:   frameCnt_d = frameCnt_q - ONE;
      default: frameCnt_d = frameCnt_q;
    endcase

`ifdef FRAME_FIFO_DROP_EN
    commitPtr_d = commitPtr_q;
    dropping_d  = dropping_q;
    frameDrop_d = 1'b0;

    if (wrAccept && wr_eod) begin
      commitPtr_d = wrPtr_q + ONE;
    end
    if (wr_en && dropping_q && wr_eod) begin
      dropping_d = 1'b0;
    end
    // A rejected word kills its frame: discard what was written and skip to the next EOD.
    if (wrReject) begin
      wrPtr_d     = commitPtr_q;
      frameDrop_d = 1'b1;
      dropping_d  = ~wr_eod;
    end
`endif
  end

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      frameCnt_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
`ifdef FRAME_FIFO_DROP_EN
      commitPtr_q <= '0;
      dropping_q  <= 1'b0;
      frameDrop_q <= 1'b0;
`endif
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      frameCnt_q  <= frameCnt_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
`ifdef FRAME_FIFO_DROP_EN
      commitPtr_q <= commitPtr_d;
      dropping_q  <= dropping_d;
      frameDrop_q <= frameDrop_d;
`endif
    end
  end

endmodule

// File: tb/tb_frame_fifo_sync.sv
// Self-checking bench for frame_fifo_sync: directed scenarios plus randomized traffic against a queue model.
// With FRAME_FIFO_DROP_EN defined only the frame-drop scenario is exercised.
module tb_frame_fifo_sync;
  import frame_fifo_pkg::*;

  logic       CLK_IN;
  logic       RST_N;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       wr_eod;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_eod;
  logic       empty;
  logic       aempty;
  logic       full;
  logic       afull;
  logic [4:0] level;
  logic [4:0] frame_cnt;
  logic       overflow;
  logic       underflow;
`ifdef FRAME_FIFO_DROP_EN
  logic       frame_drop;
`endif

  int  errors = 0;
  int  checks = 0;
  bit  checkEn = 0;

  entry_t mq[$];
  bit     mRdAcc;
  bit     mWrAcc;
  bit     expOvf;
  bit     expUnf;
  entry_t mEnt;
  int     mFrames;

  frame_fifo_sync #(
    .DATA_W    (8),
    .ADDR_W    (4),
    .AEMPTY_TH (2),
    .AFULL_TH  (12)
  ) dut (
    .CLK_IN    (CLK_IN),
    .RST_N     (RST_N),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .wr_eod    (wr_eod),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_eod    (rd_eod),
    .empty     (empty),
    .aempty    (aempty),
    .full      (full),
    .afull     (afull),
    .level     (level),
    .frame_cnt (frame_cnt),
    .overflow  (overflow),
    .underflow (underflow)
`ifdef FRAME_FIFO_DROP_EN
    ,
    .frame_drop (frame_drop)
`endif
  );

  initial begin
    CLK_IN = 1'b0;
    forever #5 CLK_IN = ~CLK_IN;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then return 1ns after the edge that consumed them.
  task automatic applyStimulus(input bit w, input logic [7:0] d, input bit e, input bit r);
    wr_en   = w;
    wr_data = d;
    wr_eod  = e;
    rd_en   = r;
    @(posedge CLK_IN);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  // Reference model: the FIFO is a queue of entries, bounded at 16.
  initial forever begin
    @(posedge CLK_IN or negedge RST_N);
    if (!RST_N) begin
      mq.delete();
      expOvf = 1'b0;
      expUnf = 1'b0;
    end else begin
      mRdAcc = rd_en && (mq.size() != 0);
      mWrAcc = wr_en && ((mq.size() < 16) || mRdAcc);
      expOvf = wr_en && !mWrAcc;
      expUnf = rd_en && (mq.size() == 0);
      if (mRdAcc) void'(mq.pop_front());
      if (mWrAcc) begin
        mEnt.eod  = wr_eod;
        mEnt.data = wr_data;
        mq.push_back(mEnt);
      end
    end
  end

  initial forever begin
    @(negedge CLK_IN);
    if (checkEn && RST_N) begin
      mFrames = 0;
      foreach (mq[k]) if (mq[k].eod) mFrames++;
      checkOutput("cmp_empty", empty, mq.size() == 0);
      checkOutput("cmp_aempty", aempty, mq.size() <= 2);
      checkOutput("cmp_full", full, mq.size() == 16);
      checkOutput("cmp_afull", afull, mq.size() >= 12);
      checkOutput("cmp_level", level, mq.size());
      checkOutput("cmp_frame_cnt", frame_cnt, mFrames);
      checkOutput("cmp_overflow", overflow, expOvf);
      checkOutput("cmp_underflow", underflow, expUnf);
      if (mq.size() != 0) begin
        checkOutput("cmp_rd_data", rd_data, mq[0].data);
        checkOutput("cmp_rd_eod", rd_eod, mq[0].eod);
      end
    end
  end

  initial begin
    int wrP;
    int rdP;
    int dropCount;
    RST_N   = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    wr_eod  = 1'b0;
    rd_en   = 1'b0;
    repeat (3) @(posedge CLK_IN);
    #3 RST_N = 1'b1;
    #1;
    checkOutput("rst_empty", empty, 1);
    checkOutput("rst_aempty", aempty, 1);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_afull", afull, 0);
    checkOutput("rst_level", level, 0);
    checkOutput("rst_frame_cnt", frame_cnt, 0);
    checkOutput("rst_overflow", overflow, 0);
    checkOutput("rst_underflow", underflow, 0);

`ifdef FRAME_FIFO_DROP_EN
    $display("[TB] frame drop scenario");
    dropCount = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 8'(8'hAA + i), i == 19, 1'b0);
      dropCount += int'(frame_drop);
      checkOutput("drop_empty", empty, 1);
      if (i == 15) checkOutput("drop_full_at16", full, 1);
      if (i == 16) checkOutput("drop_overflow_w17", overflow, 1);
    end
    checkOutput("drop_pulses", dropCount, 1);
    checkOutput("drop_level_after", level, 0);
    applyStimulus(1'b1, 8'hC0, 1'b0, 1'b0);
    checkOutput("next_hidden", empty, 1);
    applyStimulus(1'b1, 8'hC1, 1'b1, 1'b0);
    checkOutput("next_level", level, 2);
    checkOutput("next_empty", empty, 0);
    checkOutput("next_rd_data", rd_data, 8'hC0);
    checkOutput("next_frame_cnt", frame_cnt, 1);
`else
    checkEn = 1'b1;
    $display("[TB] single write");
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
    checkOutput("t1_empty", empty, 0);
    checkOutput("t1_rd_data", rd_data, 8'hAA);
    checkOutput("t1_level", level, 1);
    checkOutput("t1_aempty", aempty, 1);
    checkOutput("t1_frame_cnt", frame_cnt, 0);

    $display("[TB] fill to full");
    for (int i = 1; i < 16; i++) begin
      applyStimulus(1'b1, 8'(8'hAA + i), 1'b0, 1'b0);
      checkOutput("t2_level", level, i + 1);
      checkOutput("t2_afull", afull, (i + 1) >= 12);
      checkOutput("t2_full", full, (i + 1) == 16);
    end
    applyStimulus(1'b1, 8'hBA, 1'b0, 1'b0);
    checkOutput("t2_overflow", overflow, 1);
    checkOutput("t2_level_hold", level, 16);
    checkOutput("t2_head", rd_data, 8'hAA);

    $display("[TB] read and write while full");
    applyStimulus(1'b1, 8'hBA, 1'b0, 1'b1);
    checkOutput("t3_level", level, 16);
    checkOutput("t3_rd_data", rd_data, 8'hAB);
    checkOutput("t3_overflow", overflow, 0);
    for (int i = 0; i < 16; i++) begin
      checkOutput("t3_drain_data", rd_data, 8'(8'hAB + i));
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    end
    checkOutput("t3_empty", empty, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("t3_underflow", underflow, 1);
    checkOutput("t3_level_zero", level, 0);

    $display("[TB] two frames");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 8'(8'hBB + i), (i == 2) || (i == 5), 1'b0);
    end
    checkOutput("t4_frame_cnt", frame_cnt, 2);
    for (int i = 0; i < 3; i++) begin
      checkOutput("t4_rd_eod", rd_eod, i == 2);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    end
    checkOutput("t4_frame_cnt_after", frame_cnt, 1);
    checkOutput("t4_rd_data", rd_data, 8'hBE);

    $display("[TB] asynchronous reset mid-stream");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 8'(8'hC1 + i), 1'b0, 1'b0);
    end
    checkOutput("t5_level_pre", level, 7);
    #2 RST_N = 1'b0;
    #1;
    checkOutput("t5_level", level, 0);
    checkOutput("t5_empty", empty, 1);
    checkOutput("t5_aempty", aempty, 1);
    checkOutput("t5_frame_cnt", frame_cnt, 0);
    checkOutput("t5_afull", afull, 0);
    @(negedge CLK_IN);
    #2 RST_N = 1'b1;

    $display("[TB] randomized traffic");
    for (int i = 0; i < 1500; i++) begin
      case ((i / 150) % 3)
        0:       begin wrP = 80; rdP = 30; end
        1:       begin wrP = 25; rdP = 80; end
        default: begin wrP = 55; rdP = 55; end
      endcase
      applyStimulus($urandom_range(99) < wrP, 8'($urandom), $urandom_range(3) == 0,
                    $urandom_range(99) < rdP);
    end
    @(negedge CLK_IN);
    checkEn = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
